// File: rtl/sort_pkg.sv
// sort_pkg: shared types and helpers for the sort_engine block.
//   state_t          - engine FSM state encoding
//   RESP_OKAY        - response code meaning success (all zero)
//   STAT_WDTH        - width of the optional SORT_STATS_EN counters
//   MAX_DATA_WDTH    - widest element the compare helper supports
//   cmp_out_of_order - true when element a must move past element b
package sort_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_KEY,
    S_RD_CMP,
    S_COMPARE,
    S_WR_SHIFT,
    S_WR_KEY,
    S_NEXT_I,
    S_DONE
  } state_t;

  localparam int RESP_OKAY     = 0;
  localparam int STAT_WDTH     = 16;
  localparam int MAX_DATA_WDTH = 64;

  // Operands arrive already extended by one bit beyond MAX_DATA_WDTH
  // (sign- or zero-extended by the caller to match signed_cmp).
  function automatic logic cmp_out_of_order(input logic [MAX_DATA_WDTH:0] a,
                                            input logic [MAX_DATA_WDTH:0] b,
                                            input logic descending,
                                            input logic signed_cmp);
    logic lt, gt;
    if (signed_cmp) begin
      lt = $signed(a) < $signed(b);
      gt = $signed(a) > $signed(b);
    end else begin
      lt = a < b;
      gt = a > b;
    end
    return descending ? lt : gt;
  endfunction

endpackage

// File: rtl/sort_engine_if.sv
// sort_engine_if: single-beat AXI-lite-style memory port.
//   AR/R : read address / read data + response
//   AW/W/B : write address / write data / write response
//   master modport = sort engine, slave modport = memory.
interface sort_engine_if #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
);
  logic [ADDR_WDTH-1:0] ar_address;
  logic                 ar_valid;
  logic                 ar_ready;
  logic [DATA_WDTH-1:0] r_data;
  logic [RESP_WDTH-1:0] r_resp;
  logic                 r_valid;
  logic                 r_ready;
  logic [ADDR_WDTH-1:0] aw_address;
  logic                 aw_valid;
  logic                 aw_ready;
  logic [DATA_WDTH-1:0] w_data;
  logic                 w_valid;
  logic                 w_ready;
  logic [RESP_WDTH-1:0] b_resp;
  logic                 b_valid;
  logic                 b_ready;

  modport master (
    output ar_address, ar_valid, input ar_ready,
    input  r_data, r_resp, r_valid, output r_ready,
    output aw_address, aw_valid, input aw_ready,
    output w_data, w_valid, input w_ready,
    input  b_resp, b_valid, output b_ready
  );

  modport slave (
    input  ar_address, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready,
    input  aw_address, aw_valid, output aw_ready,
    input  w_data, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready
  );
endinterface

// File: rtl/sort_wr_channel.sv
// sort_wr_channel: performs one AW/W/B write transaction per start pulse.
//   start/addr/data : launch request (addr/data sampled with start)
//   done/resp       : combinational on the B handshake cycle
//   aw_*, w_*, b_*  : bus write channels
// AW and W rise together and drop independently on their own ready;
// b_ready rises only once both have handshaken.
module sort_wr_channel #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_WDTH-1:0] addr,
  input  logic [DATA_WDTH-1:0] data,
  output logic                 done,
  output logic [RESP_WDTH-1:0] resp,
  output logic [ADDR_WDTH-1:0] aw_address,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [DATA_WDTH-1:0] w_data,
  output logic                 w_valid,
  input  logic                 w_ready,
  input  logic [RESP_WDTH-1:0] b_resp,
  input  logic                 b_valid,
  output logic                 b_ready
);
  logic aw_ok, w_ok, pend;
  logic aw_hs, w_hs, b_hs;

  assign aw_hs = aw_valid & aw_ready;
  assign w_hs  = w_valid & w_ready;
  assign b_hs  = b_valid & b_ready;
  assign done  = b_hs;
  assign resp  = b_resp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_address <= '0;
      aw_valid   <= 1'b0;
      w_data     <= '0;
      w_valid    <= 1'b0;
      b_ready    <= 1'b0;
      aw_ok      <= 1'b0;
      w_ok       <= 1'b0;
      pend       <= 1'b0;
    end else if (start) begin
      aw_address <= addr;
      w_data     <= data;
      aw_valid   <= 1'b1;
      w_valid    <= 1'b1;
      aw_ok      <= 1'b0;
      w_ok       <= 1'b0;
      pend       <= 1'b1;
    end else begin
      if (aw_hs) begin
        aw_valid <= 1'b0;
        aw_ok    <= 1'b1;
      end
      if (w_hs) begin
        w_valid <= 1'b0;
        w_ok    <= 1'b1;
      end
      if (pend && !b_ready && (aw_ok || aw_hs) && (w_ok || w_hs))
        b_ready <= 1'b1;
      if (b_hs) begin
        b_ready <= 1'b0;
        pend    <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/sort_engine.sv
// sort_engine: in-place insertion sort over a memory port.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : request (accepted only while idle)
//   arr_size     : element count, base_addr : word address of element 0
//   descending   : sort direction, signed_cmp : two's-complement compare
//   busy/done/err: status (done is a one-cycle pulse, err is sticky)
//   bus          : sort_engine_if master (AR/R/AW/W/B)
// Optional macro SORT_STATS_EN adds saturating rd_count/wr_count outputs.
//
// state      | meaning
// S_IDLE     | waiting for start
// S_RD_KEY   | read A[i] into key
// S_RD_CMP   | read A[j] into cmp
// S_COMPARE  | decide shift / place key / already in place
// S_WR_SHIFT | write cmp to A[j+1], step j down
// S_WR_KEY   | write key to A[j+1]
// S_NEXT_I   | advance i or finish
// S_DONE     | one-cycle completion pulse
module sort_engine
  import sort_pkg::*;
#(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_WDTH:0]   arr_size,
  input  logic [ADDR_WDTH-1:0] base_addr,
  input  logic                 descending,
  input  logic                 signed_cmp,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
`ifdef SORT_STATS_EN
  output logic [STAT_WDTH-1:0] rd_count,
  output logic [STAT_WDTH-1:0] wr_count,
`endif
  sort_engine_if.master        bus
);
  localparam int JW = ADDR_WDTH + 2;
  localparam logic signed [JW-1:0] J_ONE = JW'(1);
  localparam logic [ADDR_WDTH:0]   I_ONE = (ADDR_WDTH + 1)'(1);

  state_t state, state_nxt;

  logic [ADDR_WDTH:0]     size_q, i, i_inc;
  logic [ADDR_WDTH-1:0]   base_q;
  logic                   desc_q, signed_q;
  logic signed [JW-1:0]   j, jp1, jm1, i_s;
  logic [DATA_WDTH-1:0]   key_q, cmp_q;
  logic                   rd_addr_done, wr_issued;
  logic                   r_hs, r_bad, rd_active;
  logic                   wr_start, wr_done, wr_bad;
  logic [ADDR_WDTH-1:0]   wr_addr, wr_aw_address;
  logic [DATA_WDTH-1:0]   wr_data, wr_w_data;
  logic [RESP_WDTH-1:0]   wr_resp;
  logic                   wr_aw_valid, wr_w_valid, wr_b_ready;
  logic [MAX_DATA_WDTH:0] cmp_ext, key_ext;
  logic                   out_of_order;

  assign i_s   = $signed({1'b0, i});
  assign jp1   = j + J_ONE;
  assign jm1   = j - J_ONE;
  assign i_inc = i + I_ONE;

  // Widen both operands to a common signed width so one helper covers
  // every DATA_WDTH; the extension bit follows the latched signedness.
  assign cmp_ext = {{(MAX_DATA_WDTH + 1 - DATA_WDTH){signed_q & cmp_q[DATA_WDTH-1]}}, cmp_q};
  assign key_ext = {{(MAX_DATA_WDTH + 1 - DATA_WDTH){signed_q & key_q[DATA_WDTH-1]}}, key_q};
  assign out_of_order = cmp_out_of_order(cmp_ext, key_ext, desc_q, signed_q);

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

  // Read channel: address held stable (i/j frozen in the read states).
  assign rd_active      = ((state == S_RD_KEY) && (size_q > I_ONE)) || (state == S_RD_CMP);
  assign bus.ar_valid   = rd_active && !rd_addr_done;
  assign bus.r_ready    = rd_addr_done;
  assign bus.ar_address = (state == S_RD_CMP) ? base_q + j[ADDR_WDTH-1:0] :
                          (state == S_RD_KEY) ? base_q + i[ADDR_WDTH-1:0] : '0;
  assign r_hs  = bus.r_valid && bus.r_ready;
  assign r_bad = bus.r_resp != RESP_WDTH'(RESP_OKAY);

  assign wr_start = ((state == S_WR_SHIFT) || (state == S_WR_KEY)) && !wr_issued;
  assign wr_addr  = base_q + jp1[ADDR_WDTH-1:0];
  assign wr_data  = (state == S_WR_SHIFT) ? cmp_q : key_q;
  assign wr_bad   = wr_resp != RESP_WDTH'(RESP_OKAY);

  sort_wr_channel #(
    .ADDR_WDTH(ADDR_WDTH),
    .DATA_WDTH(DATA_WDTH),
    .RESP_WDTH(RESP_WDTH)
  ) u_wr (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (wr_start),
    .addr      (wr_addr),
    .data      (wr_data),
    .done      (wr_done),
    .resp      (wr_resp),
    .aw_address(wr_aw_address),
    .aw_valid  (wr_aw_valid),
    .aw_ready  (bus.aw_ready),
    .w_data    (wr_w_data),
    .w_valid   (wr_w_valid),
    .w_ready   (bus.w_ready),
    .b_resp    (bus.b_resp),
    .b_valid   (bus.b_valid),
    .b_ready   (wr_b_ready)
  );

  assign bus.aw_address = wr_aw_address;
  assign bus.aw_valid   = wr_aw_valid;
  assign bus.w_data     = wr_w_data;
  assign bus.w_valid    = wr_w_valid;
  assign bus.b_ready    = wr_b_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_RD_KEY;
      S_RD_KEY: begin
        if (size_q <= I_ONE) state_nxt = S_DONE;
        else if (r_hs)       state_nxt = r_bad ? S_DONE : S_RD_CMP;
      end
      S_RD_CMP:   if (r_hs) state_nxt = r_bad ? S_DONE : S_COMPARE;
      S_COMPARE: begin
        if (out_of_order)    state_nxt = S_WR_SHIFT;
        else if (jp1 != i_s) state_nxt = S_WR_KEY;
        else                 state_nxt = S_NEXT_I;
      end
      S_WR_SHIFT: if (wr_done) state_nxt = wr_bad ? S_DONE : (jm1[JW-1] ? S_WR_KEY : S_RD_CMP);
      S_WR_KEY:   if (wr_done) state_nxt = wr_bad ? S_DONE : S_NEXT_I;
      S_NEXT_I:   state_nxt = (i_inc < size_q) ? S_RD_KEY : S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      size_q       <= '0;
      base_q       <= '0;
      desc_q       <= 1'b0;
      signed_q     <= 1'b0;
      i            <= '0;
      j            <= '0;
      key_q        <= '0;
      cmp_q        <= '0;
      err          <= 1'b0;
      rd_addr_done <= 1'b0;
      wr_issued    <= 1'b0;
    end else begin
      if (bus.ar_valid && bus.ar_ready) rd_addr_done <= 1'b1;
      if (r_hs)                         rd_addr_done <= 1'b0;
      if (wr_start)                     wr_issued    <= 1'b1;
      if (wr_done)                      wr_issued    <= 1'b0;
      if ((r_hs && r_bad) || (wr_done && wr_bad)) err <= 1'b1;
      case (state)
        S_IDLE: if (start) begin
          size_q   <= arr_size;
          base_q   <= base_addr;
          desc_q   <= descending;
          signed_q <= signed_cmp;
          err      <= 1'b0;
          i        <= I_ONE;
        end
        S_RD_KEY: if (r_hs && !r_bad) begin
          key_q <= bus.r_data;
          j     <= i_s - J_ONE;
        end
        S_RD_CMP:   if (r_hs && !r_bad) cmp_q <= bus.r_data;
        S_WR_SHIFT: if (wr_done && !wr_bad) j <= jm1;
        S_NEXT_I:   i <= i_inc;
        default: ;
      endcase
    end
  end

`ifdef SORT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == S_IDLE && start) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (r_hs && rd_count != '1)    rd_count <= rd_count + STAT_WDTH'(1);
      if (wr_done && wr_count != '1) wr_count <= wr_count + STAT_WDTH'(1);
    end
  end
`endif
endmodule
